hazard_forwarding_unit: RTL and testbench
=========================================

// Module: hazard_forwarding_unit
// PURPOSE
//  Drives the ID-stage pipeline muxes: forwarding selects for the rs/rt register-file port muxes and the NOP-insert select for the control-signal mux.
//  Keeps its own shadow pipeline of destination / RF-enable / load flags for the EX, MEM and WB stages.
//  From that state it detects RAW hazards, picks the youngest forwarding source, and on load-use stalls PC and IF/ID while injecting a bubble.
// PARAMETERS
//  LOAD_USE_STALLS  1   bubbles inserted per load-use hazard (legal 1..2).
//  CNT_W            16  width of the saturating stall-event counter.
// PORTS
//  clk              in   1      pipeline clock; all state on rising edge.
//  reset            in   1      synchronous, active-high reset.
//  id_rs            in   5      rs field of instruction in ID.
//  id_rt            in   5      rt field of instruction in ID.
//  id_uses_rs       in   1      ID instruction reads rs.
//  id_uses_rt       in   1      ID instruction reads rt.
//  id_dest          in   5      ID destination register (already RD/RT/R31-selected).
//  id_rf_enable     in   1      ID instruction writes the register file.
//  id_load_instr    in   1      ID instruction is a load.
//  fwd_a_sel        out  2      rs port mux select: 00 ID, 01 EX, 10 MEM, 11 WB.
//  fwd_b_sel        out  2      rt port mux select, same encoding.
//  nop_select       out  1      control mux select: 1 = zero (NOP) control into EX.
//  pc_load_enable   out  1      0 holds PC.
//  ifid_load_enable out  1      0 holds IF/ID register.
//  stall_count      out  CNT_W  number of bubble cycles inserted since reset, saturating.
// BEHAVIOUR
//  Shadow state
//   - Per stage S in {EX, MEM, WB}: S_dest[4:0], S_rfen, S_load.
//   - At each clk edge with reset low:
//     - EX <= nop_select ? {0,0,0} : {id_dest, id_rf_enable, id_load_instr}.
//     - MEM <= EX; WB <= MEM.
//   - Reset clears all shadow fields to 0 and stall_count to 0.
//  Match rule
//   - match(S,r) = S_rfen && S_dest==r && r!=0.
//   - Register 0 never matches.
//  Forwarding
//   - Combinational from shadow state and ID inputs.
//   - fwd_a_sel = 01 if match(EX,rs), else 10 if match(MEM,rs), else 11 if match(WB,rs), else 00.
//   - fwd_a_sel = 00 when id_uses_rs=0.
//   - fwd_b_sel follows the same rule using rt and id_uses_rt.
//   - EX has the highest priority (youngest producer wins).
//  Load-use stall
//   - hazard = (id_uses_rs && lmatch(rs)) || (id_uses_rt && lmatch(rt)).
//   - lmatch(r) = (EX_load && match(EX,r)) || (LOAD_USE_STALLS==2 && MEM_load && match(MEM,r)).
//   - When hazard = 1:
//     - nop_select = 1, pc_load_enable = 0, ifid_load_enable = 0, all in the same cycle (combinational).
//     - At the next edge a bubble enters EX while the ID instruction is held.
//     - The stall repeats each cycle until the load has advanced far enough that hazard = 0.
//   - Forwarding selects are still computed during a stall; the stalled cycle's value is don't-care downstream.
//  Counter
//   - stall_count increments by 1 at each edge where nop_select = 1.
//   - It holds at 2^CNT_W-1.
//  Outputs while reset is high
//   - fwd 00, nop_select 0, both load enables 1, stall_count 0.
//  Simultaneous events
//   - Reset wins over stall: a stall in progress is abandoned, and the shadow pipeline is empty on the next cycle.
// TESTING
//  T1 Forward chain:
//   - c0: dest=3, rfen=1 (non-load). c1..c4: rs=3, uses_rs=1.
//   - Expect fwd_a_sel = 01, 10, 11, 00 in c1..c4; no stall.
//  T2 Priority and R0:
//   - Two back-to-back writers of r4, then rt=4 -> fwd_b_sel = 01.
//   - Writer with dest=0 (load or not), then rs=0 -> fwd_a_sel = 00 and nop_select = 0.
//  T3 Load-use with LOAD_USE_STALLS=1:
//   - lw dest=7, then rs=7.
//   - Expect nop_select=1, pc/ifid enables 0 for exactly 1 cycle.
//   - Next cycle: fwd_a_sel = 10, stall_count = 1.
//  T4 Load-use with LOAD_USE_STALLS=2:
//   - Same stimulus as T3.
//   - Expect 2 stall cycles, then fwd_a_sel = 11, stall_count = 2.
//  T5 Reset mid-stall:
//   - Assert reset in the first stall cycle of T4.
//   - Next cycle: nop_select = 0, enables = 1, stall_count = 0, fwd selects = 00.
//  T6 Uses gating:
//   - lw dest=9, then rt=9 with uses_rt=0.
//   - Expect no stall and fwd_b_sel = 00.

Source files
------------

// File: rtl/hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_forwarding_unit
//  Purpose  : ID-stage hazard unit. Tracks destination / RF-write / load flags
//             of the instructions in EX, MEM and WB in a private shadow
//             pipeline, and from it drives the rs/rt forwarding mux selects,
//             the NOP-insert select of the control mux, and the PC / IF-ID
//             hold enables on load-use hazards. Counts inserted bubbles.
//  Ports    : clk, reset (sync, active-high)
//             id_rs, id_rt, id_uses_rs, id_uses_rt      - ID source operands
//             id_dest, id_rf_enable, id_load_instr      - ID producer info
//             fwd_a_sel, fwd_b_sel                      - 00 ID,01 EX,10 MEM,11 WB
//             nop_select                                - 1 = bubble into EX
//             pc_load_enable, ifid_load_enable          - 0 = hold
//             stall_count                               - saturating bubble count
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_forwarding_unit #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_rf_enable,
    input  logic             id_load_instr,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             nop_select,
    output logic             pc_load_enable,
    output logic             ifid_load_enable,
    output logic [CNT_W-1:0] stall_count
);

    // With two bubbles per load-use, a load still in MEM also blocks ID.
    localparam bit c_DEEP_STALL = (LOAD_USE_STALLS == 2);

    logic [4:0]       r_ex_dest, r_mem_dest, r_wb_dest;
    logic             r_ex_rfen, r_mem_rfen, r_wb_rfen;
    logic             r_ex_load, r_mem_load, r_wb_load;
    logic [CNT_W-1:0] r_cnt;

    logic             w_hazard;
    logic             w_lm_rs, w_lm_rt;

    // Register 0 is hard-wired zero, so a write to it is never a producer.
    function automatic logic f_match(input logic rfen, input logic [4:0] dest,
                                     input logic [4:0] r);
        return rfen && (dest == r) && (r != 5'd0);
    endfunction

    // Youngest producer wins: EX before MEM before WB.
    function automatic logic [1:0] f_sel(input logic uses, input logic [4:0] r,
        input logic ex_rfen,  input logic [4:0] ex_dest,
        input logic mem_rfen, input logic [4:0] mem_dest,
        input logic wb_rfen,  input logic [4:0] wb_dest);
        if (!uses)                              return 2'b00;
        else if (f_match(ex_rfen, ex_dest, r))   return 2'b01;
        else if (f_match(mem_rfen, mem_dest, r)) return 2'b10;
        else if (f_match(wb_rfen, wb_dest, r))   return 2'b11;
        else                                    return 2'b00;
    endfunction

    always_comb begin
        w_lm_rs  = (r_ex_load && f_match(r_ex_rfen, r_ex_dest, id_rs)) ||
                   (c_DEEP_STALL && r_mem_load && f_match(r_mem_rfen, r_mem_dest, id_rs));
        w_lm_rt  = (r_ex_load && f_match(r_ex_rfen, r_ex_dest, id_rt)) ||
                   (c_DEEP_STALL && r_mem_load && f_match(r_mem_rfen, r_mem_dest, id_rt));
        w_hazard = (id_uses_rs && w_lm_rs) || (id_uses_rt && w_lm_rt);
    end

    // Outputs are forced to their idle values while reset is asserted.
    always_comb begin
        fwd_a_sel        = 2'b00;
        fwd_b_sel        = 2'b00;
        nop_select       = 1'b0;
        pc_load_enable   = 1'b1;
        ifid_load_enable = 1'b1;
        stall_count      = '0;
        if (!reset) begin
            fwd_a_sel        = f_sel(id_uses_rs, id_rs, r_ex_rfen, r_ex_dest,
                                     r_mem_rfen, r_mem_dest, r_wb_rfen, r_wb_dest);
            fwd_b_sel        = f_sel(id_uses_rt, id_rt, r_ex_rfen, r_ex_dest,
                                     r_mem_rfen, r_mem_dest, r_wb_rfen, r_wb_dest);
            nop_select       = w_hazard;
            pc_load_enable   = !w_hazard;
            ifid_load_enable = !w_hazard;
            stall_count      = r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_dest  <= 5'd0;
            r_ex_rfen  <= 1'b0;
            r_ex_load  <= 1'b0;
            r_mem_dest <= 5'd0;
            r_mem_rfen <= 1'b0;
            r_mem_load <= 1'b0;
            r_wb_dest  <= 5'd0;
            r_wb_rfen  <= 1'b0;
            r_wb_load  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            // A bubble carries no producer information into EX.
            if (w_hazard) begin
                r_ex_dest <= 5'd0;
                r_ex_rfen <= 1'b0;
                r_ex_load <= 1'b0;
            end else begin
                r_ex_dest <= id_dest;
                r_ex_rfen <= id_rf_enable;
                r_ex_load <= id_load_instr;
            end
            r_mem_dest <= r_ex_dest;
            r_mem_rfen <= r_ex_rfen;
            r_mem_load <= r_ex_load;
            r_wb_dest  <= r_mem_dest;
            r_wb_rfen  <= r_mem_rfen;
            r_wb_load  <= r_mem_load;
            if (w_hazard && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_forwarding_unit
//  Purpose  : Directed bench for hazard_forwarding_unit. Two instances share
//             the same stimulus: dut1 (1 bubble per load-use, 2-bit counter
//             so saturation is reachable) and dut2 (2 bubbles, 16-bit counter).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forwarding_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_uses_rs, id_uses_rt, id_rf_enable, id_load_instr;

    logic [1:0]  fa1, fb1, fa2, fb2;
    logic        nop1, pc1, ifid1, nop2, pc2, ifid2;
    logic [1:0]  cnt1;
    logic [15:0] cnt2;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hazard_forwarding_unit #(.LOAD_USE_STALLS(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1), .nop_select(nop1),
        .pc_load_enable(pc1), .ifid_load_enable(ifid1), .stall_count(cnt1)
    );

    hazard_forwarding_unit #(.LOAD_USE_STALLS(2), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
        .fwd_a_sel(fa2), .fwd_b_sel(fb2), .nop_select(nop2),
        .pc_load_enable(pc2), .ifid_load_enable(ifid2), .stall_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One ID cycle: inputs change just after the edge, outputs sampled mid-cycle.
    task automatic drive(input logic [4:0] dest, input logic rfen, input logic load,
                         input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt);
        @(posedge clk);
        #1;
        id_dest = dest; id_rf_enable = rfen; id_load_instr = load;
        id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        #2;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        id_dest = 5'd0; id_rf_enable = 1'b0; id_load_instr = 1'b0;
        id_rs = 5'd0; id_uses_rs = 1'b0; id_rt = 5'd0; id_uses_rt = 1'b0;
        @(posedge clk);
        #3;
        // Reset state
        chk("rst_fwd_a", fa1, 2'b00);
        chk("rst_nop", nop2, 1'b0);
        chk("rst_pc", pc2, 1'b1);
        chk("rst_ifid", ifid1, 1'b1);
        chk("rst_cnt", cnt2, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // T1: forwarding chain EX -> MEM -> WB -> RF
        drive(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        chk("t1_c1_ex", fa1, 2'b01);
        chk("t1_c1_nop", nop1, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        chk("t1_c2_mem", fa1, 2'b10);
        drive(5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        chk("t1_c3_wb", fa2, 2'b11);
        drive(5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        chk("t1_c4_rf", fa1, 2'b00);

        // T2: youngest producer wins; r0 never forwards nor stalls
        drive(5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        chk("t2_prio_b", fb1, 2'b01);
        chk("t2_prio_a", fa1, 2'b00);
        drive(5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        chk("t2_r0_fwd", fa2, 2'b00);
        chk("t2_r0_nop", nop2, 1'b0);

        // T3/T4: load-use, one bubble on dut1, two on dut2
        do_reset();
        drive(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        chk("t3_s1_nop", nop1, 1'b1);
        chk("t3_s1_pc", pc1, 1'b0);
        chk("t3_s1_ifid", ifid1, 1'b0);
        chk("t4_s1_nop", nop2, 1'b1);
        drive(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        chk("t3_after_nop", nop1, 1'b0);
        chk("t3_after_pc", pc1, 1'b1);
        chk("t3_after_fwd", fa1, 2'b10);
        chk("t3_after_cnt", cnt1, 2'd1);
        chk("t4_s2_nop", nop2, 1'b1);
        chk("t4_s2_ifid", ifid2, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        chk("t4_after_nop", nop2, 1'b0);
        chk("t4_after_fwd", fa2, 2'b11);
        chk("t4_after_cnt", cnt2, 16'd2);
        chk("t3_cnt_hold", cnt1, 2'd1);

        // T5: reset in the first stall cycle
        do_reset();
        drive(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        chk("t5_stall", nop2, 1'b1);
        reset = 1'b1;
        #1;
        chk("t5_rst_nop", nop2, 1'b0);
        chk("t5_rst_pc", pc2, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("t5_nop", nop2, 1'b0);
        chk("t5_ifid", ifid2, 1'b1);
        chk("t5_cnt", cnt2, 16'd0);
        chk("t5_fwd_a", fa2, 2'b00);

        // T6: unused operand neither forwards nor stalls
        do_reset();
        drive(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0);
        chk("t6_nop1", nop1, 1'b0);
        chk("t6_nop2", nop2, 1'b0);
        chk("t6_fwd_b", fb2, 2'b00);
        drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        chk("t6_used_fwd_b", fb1, 2'b10);

        // Counter saturation on the 2-bit counter of dut1
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            drive(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
            chk("sat_stall", nop1, 1'b1);
            drive(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
            chk("sat_cnt1", cnt1, (i > 3) ? 32'd3 : i);
        end
        idle();
        chk("sat_final1", cnt1, 2'd3);
        chk("sat_final2", cnt2, 16'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
